sram_controller: RTL and testbench
==================================

# sram_controller

Multi-cycle data-memory controller between the MEM stage and an external 16-bit asynchronous SRAM. Each 32-bit load/store from the MEM stage becomes two halfword SRAM accesses with programmable wait states. While an access is in flight, `ready` is low; the pipeline uses `~ready` as a global freeze.

## Interface
- `BASE_ADDR`, 1024: byte address that maps to SRAM halfword 0.
- `WAIT_STATES`, 4: cycles per halfword phase; legal range 2..15.
- `SRAM_AW`, 18: SRAM halfword address width.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `rd_en` in 1: load request from MEM stage; held until `ready`.
- `wr_en` in 1: store request from MEM stage; held until `ready`.
- `address` in 32: byte address of the request; word-aligned.
- `write_data` in 32: store data.
- `read_data` out 32: registered load result.
- `ready` out 1: combinational; high means the MEM stage may advance.
- `addr_err` out 1: out-of-window access flag.
- `sram_addr` out `SRAM_AW`: SRAM halfword address.
- `sram_dq_out` out 16: write data driven to the SRAM pad.
- `sram_dq_oe` out 1: pad output enable.
- `sram_dq_in` in 16: read data from the SRAM pad.
- `sram_we_n` out 1: SRAM write strobe, active-low.

## Operation
- FSM states:
  - IDLE: idle, waiting for a request.
  - LOW: transfers the low halfword.
  - HIGH: transfers the high halfword.
  - DONE: signals completion for one cycle.
- Transitions:
  - IDLE goes to LOW on `rd_en | wr_en`.
  - LOW goes to HIGH after `WAIT_STATES` cycles.
  - HIGH goes to DONE after `WAIT_STATES` cycles.
  - DONE always goes to IDLE.
- Request and address latch: the request type (read/write), `address` and `write_data` are latched on the IDLE→LOW edge.
- Simultaneous `rd_en` and `wr_en`: the read is performed and the write is dropped.
- Address mapping:
  - `off = address - BASE_ADDR` (32-bit, unsigned).
  - `word = off[SRAM_AW:2]`.
  - LOW phase drives `sram_addr = {word, 1'b0}`.
  - HIGH phase drives `sram_addr = {word, 1'b1}`.
- Write phases:
  - `sram_dq_oe = 1` for every cycle of LOW and HIGH.
  - `sram_dq_out` = bits [15:0] in LOW, bits [31:16] in HIGH.
  - `sram_we_n = 0` for every phase cycle except the last one of each phase, giving hold time before the address changes.
- Read phases:
  - `sram_dq_oe = 0` and `sram_we_n = 1`.
  - `sram_dq_in` is captured into `read_data[15:0]` on the last LOW cycle and into `read_data[31:16]` on the last HIGH cycle.
  - `read_data` is otherwise held, and writes never modify it.
- `ready`:
  - IDLE: `ready = ~(rd_en | wr_en)`.
  - LOW and HIGH: `ready = 0`.
  - DONE: `ready = 1`.
- Wait counter: width 4, cleared on each phase entry, wraps only via the phase transition.

## Timing
- Reset values (asynchronous, immediate on `rst` low): state IDLE, counter 0, `read_data` 0, `sram_addr` 0, `sram_dq_out` 0, `sram_dq_oe` 0, `sram_we_n` 1, `addr_err` 0.
- Latency, counting the request's first cycle as cycle 0:
  - `ready` is low for cycles 0 .. 2·`WAIT_STATES`.
  - `ready` is high in cycle 2·`WAIT_STATES`+1.
  - With `WAIT_STATES`=4, `ready` is high in cycle 9.
- `read_data` is valid in the DONE cycle.
- Back-to-back requests: a new request arriving in the cycle after DONE is accepted by IDLE with no extra bubble.
- Reset mid-access: the access is aborted and `sram_we_n` returns to 1 asynchronously. A half-written word in SRAM is permitted.
- Request deasserted before `ready`: this is illegal, and the access completes anyway.

## Configuration
- `SRAM_ADDR_CHECK_EN` defined:
  - A request with `address < BASE_ADDR` or `off >= 2^(SRAM_AW+1)` goes IDLE→DONE directly, with no SRAM strobes.
  - `addr_err = 1` in that DONE cycle.
  - On a read, `read_data` is set to 0.
- `SRAM_ADDR_CHECK_EN` undefined:
  - `addr_err` is tied to 0.
  - The offset is truncated, so addresses wrap modulo the SRAM size.

## Structure
- Package `sram_ctrl_pkg` holds:
  - the FSM state enum (IDLE/LOW/HIGH/DONE);
  - default constants for `BASE_ADDR`, `WAIT_STATES` and `SRAM_AW`;
  - the halfword-select localparams.
- Single module; no sub-module is warranted. The wait counter is inline.

## Test plan
- Reset sequence: hold `rst` low → all outputs at reset values, `ready`=1 with no request pending.
- Store then load: store `address`=1024, `write_data`=0xDEADBEEF →
  - SRAM[0]=0xBEEF, SRAM[1]=0xDEAD;
  - `sram_we_n` low for 3 cycles per phase;
  - `ready` high in cycle 9.
  - A following load of 1024 returns `read_data`=0xDEADBEEF in its DONE cycle.
- Back-to-back loads: loads of 1028 and 1032 issued back-to-back → `sram_addr` sequence 2,3 then 4,5, with exactly 10 cycles per access.
- Simultaneous requests: `rd_en`=`wr_en`=1 at 1024 → read performed, SRAM unchanged, `sram_dq_oe` never high.
- Reset mid-access: `rst` asserted in cycle 6 of a store → `sram_we_n`=1 immediately; after release, state is IDLE and `ready`=1.
- Address check, with `SRAM_ADDR_CHECK_EN`: load of address 16 →
  - `ready` high in cycle 1;
  - `addr_err`=1;
  - `read_data`=0;
  - no SRAM strobes.
- Address check, without `SRAM_ADDR_CHECK_EN`: the same load of address 16 wraps to the high end of SRAM, with normal 10-cycle latency.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the 32-bit to 16-bit asynchronous SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
    localparam int          DEF_WAIT_STATES = 4;
    localparam int          DEF_SRAM_AW     = 18;

    // Halfword select appended as the SRAM address LSB.
    localparam logic HW_LO = 1'b0;
    localparam logic HW_HI = 1'b1;

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage request/response bus plus the SRAM pad signals of the data-memory controller.
interface sram_controller_if
    import sram_ctrl_pkg::*;
#(
    parameter int SRAM_AW = DEF_SRAM_AW
);
    logic                rd_en;
    logic                wr_en;
    logic [31:0]         address;
    logic [31:0]         write_data;
    logic [31:0]         read_data;
    logic                ready;
    logic                addr_err;
    logic [SRAM_AW-1:0]  sram_addr;
    logic [15:0]         sram_dq_out;
    logic                sram_dq_oe;
    logic [15:0]         sram_dq_in;
    logic                sram_we_n;

    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, addr_err, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, addr_err, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two halfword SRAM accesses (SRAM_ADDR_CHECK_EN adds window check).
// Latency: ready rises 2*WAIT_STATES+1 cycles after the request (1 cycle for an out-of-window access).
// Backpressure: ready is low while an access is in flight; the pipeline freezes on ~ready.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          WAIT_STATES = DEF_WAIT_STATES,
    parameter int          SRAM_AW     = DEF_SRAM_AW
) (
    input  logic              clk,
    input  logic              rst,
    sram_controller_if.slave  bus
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES - 1);
    localparam int         WORD_W   = SRAM_AW - 1;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                is_wr_q, is_wr_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [31:0]         wdata_q, wdata_d;

    logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;
    logic [15:0]         dq_out_q, dq_out_d;
    logic                oe_q, oe_d;
    logic                we_n_q, we_n_d;
    logic [31:0]         read_data_q;

    logic [31:0]         off;
    logic                req;
    logic                last;
    logic                phase_d;
    logic                unused_off;

    assign req  = bus.rd_en | bus.wr_en;
    assign off  = bus.address - BASE_ADDR;
    assign last = (cnt_q == LAST_CNT);
    assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};

`ifdef SRAM_ADDR_CHECK_EN
    logic bad_addr;
    logic err_q, err_d;
    assign bad_addr = (bus.address < BASE_ADDR) || (off[31:SRAM_AW+1] != '0);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 4'd1;
        is_wr_d = is_wr_q;
        word_d  = word_q;
        wdata_d = wdata_q;
`ifdef SRAM_ADDR_CHECK_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (req) begin
                    // A simultaneous read and write resolves to the read.
                    is_wr_d = bus.wr_en & ~bus.rd_en;
                    word_d  = off[SRAM_AW:2];
                    wdata_d = bus.write_data;
                    state_d = LOW;
`ifdef SRAM_ADDR_CHECK_EN
                    if (bad_addr) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            LOW: begin
                if (last) begin
                    state_d = HIGH;
                    cnt_d   = 4'd0;
                end
            end
            HIGH: begin
                if (last) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Pad outputs are registered from the next-cycle state so they are glitch-free.
    always_comb begin
        phase_d     = (state_d == LOW) || (state_d == HIGH);
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        oe_d        = 1'b0;
        we_n_d      = 1'b1;
        if (phase_d) begin
            sram_addr_d = {word_d, (state_d == HIGH) ? HW_HI : HW_LO};
            if (is_wr_d) begin
                dq_out_d = (state_d == HIGH) ? wdata_d[31:16] : wdata_d[15:0];
                oe_d     = 1'b1;
                // Strobe released on the final phase cycle for hold before the address moves.
                we_n_d   = (cnt_d == LAST_CNT);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            is_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            oe_q        <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            oe_q        <= oe_d;
            we_n_q      <= we_n_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data_q <= '0;
        end else begin
            if (!is_wr_q && last) begin
                if (state_q == LOW)  read_data_q[15:0]  <= bus.sram_dq_in;
                if (state_q == HIGH) read_data_q[31:16] <= bus.sram_dq_in;
            end
`ifdef SRAM_ADDR_CHECK_EN
            if (state_q == IDLE && bus.rd_en && bad_addr) read_data_q <= '0;
`endif
        end
    end

`ifdef SRAM_ADDR_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end
    assign bus.addr_err = err_q;
`else
    assign bus.addr_err = 1'b0;
`endif

    assign bus.ready       = (state_q == IDLE) ? ~req : (state_q == DONE);
    assign bus.read_data   = read_data_q;
    assign bus.sram_addr   = sram_addr_q;
    assign bus.sram_dq_out = dq_out_q;
    assign bus.sram_dq_oe  = oe_q;
    assign bus.sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller (default build) with a behavioural 16-bit SRAM.
module tb_sram_controller;
    import sram_ctrl_pkg::*;

    localparam int WS = 4;
    localparam int AW = 18;

    logic clk = 1'b0;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    int            lat, we_lo, we_hi, oe_cnt;
    logic [AW-1:0] a_lo, a_hi;
    logic [31:0]   rd_val;

    logic [15:0] mem [0:(1<<AW)-1];

    sram_controller_if #(.SRAM_AW(AW)) bus ();

    sram_controller #(
        .BASE_ADDR   (32'd1024),
        .WAIT_STATES (WS),
        .SRAM_AW     (AW)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.sram_dq_in = mem[bus.sram_addr];

    always @(posedge clk) begin
        if (!bus.sram_we_n && bus.sram_dq_oe) mem[bus.sram_addr] <= bus.sram_dq_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drives a request at a negedge (cycle 0) and holds it until ready, recording pad activity.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus.rd_en = rd;
        bus.wr_en = wr;
        bus.address = a;
        bus.write_data = wd;
        #1;
        lat = 0; we_lo = 0; we_hi = 0; oe_cnt = 0;
        a_lo = '1; a_hi = '1;
        while (!bus.ready && lat < 40) begin
            @(negedge clk);
            #1;
            lat++;
            if (!bus.ready) begin
                if (!bus.sram_we_n) begin
                    if (bus.sram_addr[0]) we_hi++;
                    else                  we_lo++;
                end
                if (bus.sram_dq_oe) oe_cnt++;
                if (lat == 1)      a_lo = bus.sram_addr;
                if (lat == WS + 1) a_hi = bus.sram_addr;
            end
        end
        rd_val = bus.read_data;
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.address = '0;
        bus.write_data = '0;
    endtask

    initial begin
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.address = '0;
        bus.write_data = '0;
        mem[0] = 16'h0000; mem[1] = 16'h0000;
        mem[2] = 16'h3333; mem[3] = 16'h4444;
        mem[4] = 16'h5555; mem[5] = 16'h6666;
        mem[18'h3FE08] = 16'h1234;
        mem[18'h3FE09] = 16'h5678;

        // Reset state
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready",     32'(bus.ready), 32'd1);
        chk("rst_read_data", bus.read_data, 32'h0);
        chk("rst_sram_addr", 32'(bus.sram_addr), 32'h0);
        chk("rst_dq_out",    32'(bus.sram_dq_out), 32'h0);
        chk("rst_dq_oe",     32'(bus.sram_dq_oe), 32'd0);
        chk("rst_we_n",      32'(bus.sram_we_n), 32'd1);
        chk("rst_addr_err",  32'(bus.addr_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Store 0xDEADBEEF at 1024
        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        chk("st_latency", 32'(lat), 32'd9);
        chk("st_we_lo",   32'(we_lo), 32'd3);
        chk("st_we_hi",   32'(we_hi), 32'd3);
        chk("st_addr_lo", 32'(a_lo), 32'd0);
        chk("st_addr_hi", 32'(a_hi), 32'd1);
        go_idle();
        chk("st_mem0", 32'(mem[0]), 32'h0000BEEF);
        chk("st_mem1", 32'(mem[1]), 32'h0000DEAD);
        chk("st_read_data_kept", bus.read_data, 32'h0);

        // Load back from 1024
        access(1'b1, 1'b0, 32'd1024, 32'h0);
        chk("ld_latency", 32'(lat), 32'd9);
        chk("ld_data",    rd_val, 32'hDEADBEEF);
        chk("ld_oe",      32'(oe_cnt), 32'd0);
        chk("ld_we",      32'(we_lo + we_hi), 32'd0);
        go_idle();

        // Back-to-back loads of 1028 and 1032
        access(1'b1, 1'b0, 32'd1028, 32'h0);
        chk("b2b0_latency", 32'(lat), 32'd9);
        chk("b2b0_addr_lo", 32'(a_lo), 32'd2);
        chk("b2b0_addr_hi", 32'(a_hi), 32'd3);
        chk("b2b0_data",    rd_val, 32'h44443333);
        access(1'b1, 1'b0, 32'd1032, 32'h0);
        chk("b2b1_latency", 32'(lat), 32'd9);
        chk("b2b1_addr_lo", 32'(a_lo), 32'd4);
        chk("b2b1_addr_hi", 32'(a_hi), 32'd5);
        chk("b2b1_data",    rd_val, 32'h66665555);
        go_idle();

        // Simultaneous read and write: read wins
        access(1'b1, 1'b1, 32'd1024, 32'h11112222);
        chk("sim_latency", 32'(lat), 32'd9);
        chk("sim_data",    rd_val, 32'hDEADBEEF);
        chk("sim_oe",      32'(oe_cnt), 32'd0);
        go_idle();
        chk("sim_mem0", 32'(mem[0]), 32'h0000BEEF);
        chk("sim_mem1", 32'(mem[1]), 32'h0000DEAD);

        // Reset in cycle 6 of a store
        @(negedge clk);
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b1;
        bus.address = 32'd1024;
        bus.write_data = 32'hCAFEF00D;
        repeat (6) @(negedge clk);
        #1;
        chk("mid_we_n_c6", 32'(bus.sram_we_n), 32'd0);
        chk("mid_addr_c6", 32'(bus.sram_addr), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we_n", 32'(bus.sram_we_n), 32'd1);
        chk("mid_rst_oe",   32'(bus.sram_dq_oe), 32'd0);
        chk("mid_rst_addr", 32'(bus.sram_addr), 32'd0);
        bus.wr_en = 1'b0;
        bus.address = '0;
        bus.write_data = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_post_ready", 32'(bus.ready), 32'd1);
        access(1'b1, 1'b0, 32'd1024, 32'h0);
        chk("mid_ld_latency", 32'(lat), 32'd9);
        chk("mid_ld_data",    rd_val, 32'hCAFEF00D);
        go_idle();

        // Address below the window wraps to the top of SRAM
        access(1'b1, 1'b0, 32'd16, 32'h0);
        chk("wrap_latency",  32'(lat), 32'd9);
        chk("wrap_addr_lo",  32'(a_lo), 32'h3FE08);
        chk("wrap_addr_hi",  32'(a_hi), 32'h3FE09);
        chk("wrap_data",     rd_val, 32'h56781234);
        chk("wrap_addr_err", 32'(bus.addr_err), 32'd0);
        go_idle();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
